// File: rtl/sdp_fifo_ctrl.sv
// FIFO controller for an external simple dual-port RAM with registered read.
// A 2-entry head/skid output stage hides the read latency and gives a FWFT output stream.
module sdp_fifo_ctrl #(
   parameter int addr_width = 8,
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [data_width-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [data_width-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [addr_width+1:0] count,
   output logic [addr_width-1:0] ram_waddr,
   output logic [data_width-1:0] ram_din,
   output logic                  ram_we,
   output logic [addr_width-1:0] ram_raddr,
   input  logic [data_width-1:0] ram_dout
);

   logic [addr_width-1:0] wptr_q, wptr_d;
   logic [addr_width-1:0] rptr_q, rptr_d;
   logic [addr_width:0]   ram_cnt_q, ram_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [1:0]            ost_cnt_q, ost_cnt_d;
   logic [data_width-1:0] head_q, head_d;
   logic [data_width-1:0] skid_q, skid_d;

   logic       push, pop, issue;
   logic [2:0] occ;

   // Full is judged on the RAM region alone so a same-cycle issue never frees the slot being written.
   assign in_ready  = ~ram_cnt_q[addr_width];
   assign push      = in_valid & in_ready;
   assign out_valid = (ost_cnt_q != 2'd0);
   assign pop       = out_valid & out_ready;
   assign out_data  = head_q;

   assign occ   = {1'b0, ost_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
   assign issue = (ram_cnt_q != '0) && (occ < 3'd2);

   assign ram_waddr = wptr_q;
   assign ram_din   = in_data;
   assign ram_we    = push;
   assign ram_raddr = rptr_q;

   assign count = {1'b0, ram_cnt_q} + {{(addr_width+1){1'b0}}, rd_pend_q}
                + {{addr_width{1'b0}}, ost_cnt_q};

   always_comb begin
      wptr_d    = wptr_q + {{(addr_width-1){1'b0}}, push};
      rptr_d    = rptr_q + {{(addr_width-1){1'b0}}, issue};
      ram_cnt_d = ram_cnt_q + {{addr_width{1'b0}}, push} - {{addr_width{1'b0}}, issue};
      rd_pend_d = issue;
      ost_cnt_d = ost_cnt_q;
      head_d    = head_q;
      skid_d    = skid_q;
      case ({rd_pend_q, pop})
         2'b10: begin
            if (ost_cnt_q == 2'd0) head_d = ram_dout;
            else                   skid_d = ram_dout;
            ost_cnt_d = ost_cnt_q + 2'd1;
         end
         2'b01: begin
            head_d    = skid_q;
            ost_cnt_d = ost_cnt_q - 2'd1;
         end
         2'b11: begin
            // Capture and pop together: the new word lands behind whatever remains.
            if (ost_cnt_q == 2'd1) begin
               head_d = ram_dout;
            end else begin
               head_d = skid_q;
               skid_d = ram_dout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ram_cnt_q <= '0;
         rd_pend_q <= 1'b0;
         ost_cnt_q <= 2'd0;
         head_q    <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ram_cnt_q <= ram_cnt_d;
         rd_pend_q <= rd_pend_d;
         ost_cnt_q <= ost_cnt_d;
         head_q    <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Randomized bench for sdp_fifo_ctrl with a RAM model and a queue-level reference model.
module tb_sdp_fifo_ctrl;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW+1:0] count;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [DW-1:0] ram_din, ram_dout;
   logic          ram_we;

   sdp_fifo_ctrl #(.addr_width(AW), .data_width(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count),
      .ram_waddr(ram_waddr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_raddr(ram_raddr), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Simple dual-port RAM: synchronous write, registered read every cycle.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_din;
      ram_dout <= mem[ram_raddr];
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: every held word in arrival order, plus how many sit in the output stage / in flight.
   logic [DW-1:0] q[$];
   int m_ost = 0;
   int m_inf = 0;
   logic [DW-1:0] last_data;
   logic          last_stall = 1'b0;

   task automatic model_reset();
      q.delete();
      m_ost = 0;
      m_inf = 0;
      last_stall = 1'b0;
   endtask

   task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
      int ram_used, ppop, ppush, piss;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      ram_used = q.size() - m_ost - m_inf;
      ppop  = (m_ost > 0 && ordy) ? 1 : 0;
      ppush = (iv && ram_used < DEPTH) ? 1 : 0;
      piss  = (ram_used > 0 && (m_ost + m_inf - ppop) < 2) ? 1 : 0;
      chk("out_valid", {31'd0, out_valid}, (m_ost > 0) ? 1 : 0);
      if (m_ost > 0) chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
      chk("count", {22'd0, count}, q.size());
      chk("in_ready", {31'd0, in_ready}, (ram_used < DEPTH) ? 1 : 0);
      chk("ram_we", {31'd0, ram_we}, ppush);
      if (last_stall && out_valid) chk("stall_hold", {24'd0, out_data}, {24'd0, last_data});
      last_stall = out_valid & ~ordy;
      last_data  = out_data;
      if (ppop == 1) void'(q.pop_front());
      if (ppush == 1) q.push_back(d);
      m_ost = m_ost - ppop + m_inf;
      m_inf = piss;
      @(posedge clk);
      #1;
   endtask

   int pops;

   initial begin
      // Reset and idle
      #3;
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_data", {24'd0, out_data}, 0);
      chk("rst_count", {22'd0, count}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_ram_we", {31'd0, ram_we}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

      // Single word: visible two cycles after the push edge
      step(1'b1, 8'hA5, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      chk("single_valid", {31'd0, out_valid}, 1);
      chk("single_data", {24'd0, out_data}, 32'hA5);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

      // Fill under backpressure, then drain
      for (int i = 0; i < 258; i++) step(1'b1, DW'(i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0);
      chk("full_count", {22'd0, count}, 258);
      chk("full_in_ready", {31'd0, in_ready}, 0);
      for (int i = 0; i < 262; i++) step(1'b0, 8'h00, 1'b1);
      chk("drained_count", {22'd0, count}, 0);

      // Streaming across two pointer wraps
      pops = 0;
      for (int i = 0; i < 600; i++) begin
         if (i >= 3 && out_valid) pops++;
         step(1'b1, DW'(i), 1'b1);
      end
      chk("stream_rate", pops, 597);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

      // Random traffic
      for (int i = 0; i < 5000; i++)
         step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1);
      chk("rand_drained", {22'd0, count}, 0);

      // Async reset between edges with 100 words held
      for (int i = 0; i < 100; i++) step(1'b1, DW'(i + 7), 1'b0);
      chk("pre_rst_count", {22'd0, count}, 100);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 0);
      chk("async_count", {22'd0, count}, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1'b1, 8'h3C, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("post_rst_first", {24'd0, out_data}, 32'h3C);
      chk("post_rst_count", {22'd0, count}, 1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/sdp_fifo_ctrl.md
Name: sdp_fifo_ctrl

Overview:
- Single-clock FIFO controller that drives an external simple dual-port RAM and hides its 1-cycle registered read latency.
- The RAM has a synchronous write and a registered read with no read enable: dout is loaded from mem[raddr] on every clock.
- Upstream side is a valid/ready write stream. Downstream side is a first-word-fall-through valid/ready stream served from a 2-entry output stage.
- Sits directly upstream of the RAM macro (owns its write and read address buses) and directly downstream of its dout.

Parameters:
- addr_width, 8, RAM address width; RAM storage depth = 2^addr_width.
- data_width, 8, data word width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  data_width  write data.
- in_valid  in  1  write request.
- in_ready  out  1  write accepted when in_valid && in_ready.
- out_data  out  data_width  head-of-queue data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  pop occurs when out_valid && out_ready.
- count  out  addr_width+2  total words held (RAM + in-flight read + output stage); range 0 to 2^addr_width+2.
- ram_waddr  out  addr_width  RAM write address (= wptr).
- ram_din  out  data_width  RAM write data (= in_data).
- ram_we  out  1  RAM write enable (= push).
- ram_raddr  out  addr_width  RAM read address (= rptr).
- ram_dout  in  data_width  RAM registered read data.

Behaviour:
- Reset (async, rst_n=0):
  - wptr=0, rptr=0, ram_cnt=0, rd_pending=0, ostage empty.
  - Outputs: out_valid=0, out_data=0, in_ready=1, count=0, ram_we=0.
  - Reset mid-operation discards all contents; RAM contents are ignored afterwards.
- Push:
  - in_ready = (ram_cnt < 2^addr_width); registered-state only, no combinational path from out_ready.
  - push = in_valid && in_ready; ram_we = push.
  - On push, wptr increments and wraps modulo 2^addr_width.
- Issue (RAM read):
  - issue = (ram_cnt != 0) && (ost_cnt + rd_pending - pop < 2), where pop = out_valid && out_ready.
  - On issue: rptr increments (wraps) and rd_pending <= 1; otherwise rd_pending <= 0.
  - ram_raddr = rptr at all times. The RAM reads every cycle; data is used only when rd_pending=1.
- Capture: when rd_pending=1, ram_dout is written into the output stage that edge.
  - Output stage is a head register plus a skid register.
  - Order is preserved; the head always holds the oldest word.
- ram_cnt update: +push −issue, both may occur in the same cycle.
- count = ram_cnt + rd_pending + ost_cnt.
- Latency:
  - Word pushed at edge E0 into an empty FIFO: issued at E1, captured at E2; out_valid=1 after E2 (2 cycles).
  - No bypass path from in_data to out_data.
- Throughput: sustained 1 push and 1 pop per cycle once primed.
- Boundaries:
  - RAM region full (ram_cnt = 2^addr_width): in_ready=0 even if an issue happens the same cycle. This avoids a same-address read/write collision, which the RAM leaves undefined.
  - Empty: no issue and out_valid=0. A pop with out_valid=0 is ignored.
  - Issue never targets the address written in the same cycle; a word becomes readable one cycle after its write.
  - Pointer wrap from 2^addr_width−1 to 0 is seamless.
  - Backpressure (out_ready=0): at most 2 words are held in ostage+rd_pending, so no captured data is ever dropped.
- out_data holds its value while out_valid=1 and out_ready=0.

Test Plan:
- Reset then idle: in_valid=0 for 10 cycles -> out_valid=0, in_ready=1, count=0, ram_we=0 throughout.
- Single word: push 0xA5 at cycle 0 with out_ready=1 -> out_valid=1 with out_data=0xA5 two cycles later; count goes 1,1,1,0 after the pop.
- Fill: out_ready=0, push 0..257 with addr_width=8 -> 258 words accepted (256 RAM + 2 output stage); in_ready=0 at count=258. Then drain with out_ready=1 -> 0..257 in order, one per cycle after the first.
- Streaming: in_valid=out_ready=1 with incrementing data for 600 cycles -> 1 word/cycle output, no gaps after priming, pointer wraps twice, order intact.
- Random backpressure: random in_valid/out_ready for 5000 cycles checked against a scoreboard -> no loss, duplication or reorder; out_data stable while stalled; count always matches the model.
- Async reset mid-stream: assert rst_n=0 between edges with count=100 -> out_valid and count drop to 0 immediately without waiting for a clock edge. After release, a new push of 0x3C is the first word out.
